// File: rtl/uart_transmit_fsm_if.sv
// rtl/uart_transmit_fsm_if.sv - handshake/config bundle between the UART transmitter and its FIFO/baud/register side
interface uart_transmit_fsm_if #(
  parameter int DATA_MAX = 8
);
  logic                utten;
  logic                bit_tick;
  logic [1:0]          wls;
  logic                pen;
  logic                eps;
  logic                stb;
  logic                brk;
  logic                tx_fifo_empty;
  logic [DATA_MAX-1:0] tx_fifo_rdata;
  logic                tx_fifo_pop;
  logic                uart_txd;
  logic                tx_busy;
  logic                tx_frame_done;
  logic                tx_empty;

  modport master (
    input  utten, bit_tick, wls, pen, eps, stb, brk, tx_fifo_empty, tx_fifo_rdata,
    output tx_fifo_pop, uart_txd, tx_busy, tx_frame_done, tx_empty
  );

  modport slave (
    output utten, bit_tick, wls, pen, eps, stb, brk, tx_fifo_empty, tx_fifo_rdata,
    input  tx_fifo_pop, uart_txd, tx_busy, tx_frame_done, tx_empty
  );
endinterface

// File: rtl/uart_transmit_fsm.sv
// rtl/uart_transmit_fsm.sv - UART transmit engine: start/data/parity/stop framing and line break
module uart_transmit_fsm #(
  parameter int DATA_MAX = 8
) (
  input  logic                pclk,
  input  logic                presetn,
  uart_transmit_fsm_if.master tx_if
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_MAX-1:0] shift_q, shift_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                stop_cnt_q, stop_cnt_d;
  logic                mark_q, mark_d;
  logic                parity_q, parity_d;
  logic [1:0]          wls_q, wls_d;
  logic                pen_q, pen_d;
  logic                stb_q, stb_d;
  logic                txd_q, txd_d;
  logic                rst_done_q;

  logic                tick;
  logic                load;
  logic                pop;
  logic                done;
  logic                load_par;
  logic [DATA_MAX-1:0] load_mask;
  logic [2:0]          last_idx;

  // The first edge after reset release never acts on bit_tick.
  assign tick      = tx_if.bit_tick & rst_done_q;
  assign load_mask = {DATA_MAX{1'b1}} >> (2'd3 - tx_if.wls);
  assign load_par  = (^(tx_if.tx_fifo_rdata & load_mask)) ^ ~tx_if.eps;
  assign last_idx  = {1'b0, wls_q} + 3'd4;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      stop_cnt_q <= 1'b0;
      mark_q     <= 1'b0;
      parity_q   <= 1'b0;
      wls_q      <= '0;
      pen_q      <= 1'b0;
      stb_q      <= 1'b0;
      txd_q      <= 1'b1;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      stop_cnt_q <= stop_cnt_d;
      mark_q     <= mark_d;
      parity_q   <= parity_d;
      wls_q      <= wls_d;
      pen_q      <= pen_d;
      stb_q      <= stb_d;
      txd_q      <= txd_d;
      rst_done_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    stop_cnt_d = stop_cnt_q;
    mark_d     = mark_q;
    parity_d   = parity_q;
    wls_d      = wls_q;
    pen_d      = pen_q;
    stb_d      = stb_q;
    txd_d      = txd_q;
    load       = 1'b0;
    pop        = 1'b0;
    done       = 1'b0;

    if (!tx_if.utten) begin
      state_d    = ST_IDLE;
      txd_d      = 1'b1;
      shift_d    = '0;
      cnt_d      = '0;
      stop_cnt_d = 1'b0;
      mark_d     = 1'b0;
    end else if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (tx_if.brk) begin
            state_d = ST_BREAK;
            txd_d   = 1'b0;
          end else if (!tx_if.tx_fifo_empty) begin
            load = 1'b1;
          end
        end
        ST_START: begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          if (cnt_q != last_idx) begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 3'd1;
          end else if (pen_q) begin
            txd_d   = parity_q;
            state_d = ST_PARITY;
          end else begin
            txd_d      = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = ST_STOP;
          end
        end
        ST_PARITY: begin
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = ST_STOP;
        end
        ST_STOP: begin
          // The mark bit after a break is always a single, unreported stop bit.
          if (stb_q && !mark_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b0;
            if (mark_q) begin
              mark_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              done = 1'b1;
              if (tx_if.brk) begin
                state_d = ST_BREAK;
                txd_d   = 1'b0;
              end else if (!tx_if.tx_fifo_empty) begin
                load = 1'b1;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
        ST_BREAK: begin
          if (!tx_if.brk) begin
            txd_d      = 1'b1;
            mark_d     = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = ST_STOP;
          end
        end
        default: begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
        end
      endcase

      // Shared by idle start and back-to-back start from the final stop bit.
      if (load) begin
        pop        = 1'b1;
        shift_d    = tx_if.tx_fifo_rdata;
        wls_d      = tx_if.wls;
        pen_d      = tx_if.pen;
        stb_d      = tx_if.stb;
        parity_d   = load_par;
        cnt_d      = '0;
        stop_cnt_d = 1'b0;
        mark_d     = 1'b0;
        txd_d      = 1'b0;
        state_d    = ST_START;
      end
    end
  end

  assign tx_if.tx_fifo_pop   = pop;
  assign tx_if.uart_txd      = txd_q;
  assign tx_if.tx_busy       = (state_q != ST_IDLE);
  assign tx_if.tx_frame_done = done;
  assign tx_if.tx_empty      = (state_q == ST_IDLE) & tx_if.tx_fifo_empty;

endmodule

// File: tb/tb_uart_transmit_fsm.sv
// tb/tb_uart_transmit_fsm.sv - self-checking bench for uart_transmit_fsm against a line-level frame model
module tb_uart_transmit_fsm;

  logic pclk = 1'b0;
  logic presetn = 1'b0;

  uart_transmit_fsm_if #(.DATA_MAX(8)) tx_if ();

  uart_transmit_fsm #(.DATA_MAX(8)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .tx_if   (tx_if)
  );

  always #5 pclk = ~pclk;

  // One expected line bit per tick period; sof/eof mark the pop and frame_done ticks.
  typedef struct packed {
    logic b;
    logic sof;
    logic eof;
    logic act;
  } elem_t;

  localparam elem_t IDLE_E = '{b: 1'b1, sof: 1'b0, eof: 1'b0, act: 1'b0};

  elem_t       exp_q[$];
  elem_t       cur = IDLE_E;
  logic [7:0]  fifo_q[$];
  int          errors = 0;
  int          checks = 0;
  int          act_pops = 0;
  int          act_dones = 0;
  bit          rst_seen = 1'b0;
  bit          eff_tick, seen_utten, seen_pop;
  bit          exp_pop, exp_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh_fifo();
    tx_if.tx_fifo_empty = (fifo_q.size() == 0);
    tx_if.tx_fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  function automatic void build_frame(input logic [7:0] d, input logic [1:0] w, input logic p,
                                      input logic e, input logic s,
                                      output int len, output logic [15:0] bits);
    int ones;
    int n;
    bits = '0;
    len  = 0;
    ones = 0;
    n    = 5 + int'(w);
    bits[len] = 1'b0;
    len++;
    for (int i = 0; i < n; i++) begin
      bits[len] = d[i];
      ones += int'(d[i]);
      len++;
    end
    if (p) begin
      bits[len] = e ? ((ones % 2) == 1) : ((ones % 2) == 0);
      len++;
    end
    for (int i = 0; i < (s ? 2 : 1); i++) begin
      bits[len] = 1'b1;
      len++;
    end
  endfunction

  task automatic push_frame(input logic [7:0] d);
    int          len;
    logic [15:0] bits;
    elem_t       e;
    build_frame(d, tx_if.wls, tx_if.pen, tx_if.eps, tx_if.stb, len, bits);
    for (int i = 0; i < len; i++) begin
      e.b   = bits[i];
      e.sof = (i == 0);
      e.eof = (i == len - 1);
      e.act = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(posedge pclk);
    #2;
    fifo_q.push_back(d);
    refresh_fifo();
    push_frame(d);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge pclk);
      if (exp_q.size() == 0 && !cur.act && fifo_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
    repeat (20) @(negedge pclk);
  endtask

  task automatic wait_q_le(input int n, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge pclk);
      if (exp_q.size() <= n) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    int c = 0;
    tx_if.bit_tick = 1'b0;
    forever begin
      @(posedge pclk);
      #1;
      c = (c + 1) % 16;
      tx_if.bit_tick = (c == 15);
    end
  end

  initial begin
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        exp_q.delete();
        cur      = IDLE_E;
        rst_seen = 1'b0;
      end
      eff_tick = tx_if.bit_tick && tx_if.utten && presetn && rst_seen;
      exp_pop  = eff_tick && (exp_q.size() != 0) && exp_q[0].sof;
      exp_done = eff_tick && cur.eof;
      check("txd", 32'(tx_if.uart_txd), 32'(cur.b));
      check("busy", 32'(tx_if.tx_busy), 32'(cur.act));
      check("pop", 32'(tx_if.tx_fifo_pop), 32'(exp_pop));
      check("frame_done", 32'(tx_if.tx_frame_done), 32'(exp_done));
      check("tx_empty", 32'(tx_if.tx_empty), 32'(!cur.act && fifo_q.size() == 0));
      seen_pop   = tx_if.tx_fifo_pop;
      seen_utten = tx_if.utten;
      if (seen_pop) act_pops++;
      if (tx_if.tx_frame_done) act_dones++;
      @(posedge pclk);
      if (presetn) begin
        if (!seen_utten) begin
          exp_q.delete();
          cur = IDLE_E;
        end else if (eff_tick) begin
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          else cur = IDLE_E;
        end
        rst_seen = 1'b1;
      end
      #1;
      if (seen_pop && fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
        refresh_fifo();
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int          len;
    logic [15:0] bits;
    int          p0, d0;
    bit          found;

    tx_if.utten = 1'b1;
    tx_if.wls   = 2'b11;
    tx_if.pen   = 1'b0;
    tx_if.eps   = 1'b0;
    tx_if.stb   = 1'b0;
    tx_if.brk   = 1'b0;
    refresh_fifo();

    repeat (3) @(negedge pclk);
    check("reset_txd", 32'(tx_if.uart_txd), 32'd1);
    check("reset_busy", 32'(tx_if.tx_busy), 32'd0);
    check("reset_pop", 32'(tx_if.tx_fifo_pop), 32'd0);
    check("reset_done", 32'(tx_if.tx_frame_done), 32'd0);
    check("reset_empty", 32'(tx_if.tx_empty), 32'd1);

    build_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, len, bits);
    check("model_8n1_a5", {16'(len), bits}, 32'h000A_034A);
    build_frame(8'h53, 2'b10, 1'b1, 1'b1, 1'b0, len, bits);
    check("model_7e1_53", {16'(len), bits}, 32'h000A_02A6);
    build_frame(8'h53, 2'b10, 1'b1, 1'b0, 1'b0, len, bits);
    check("model_7o1_53", {16'(len), bits}, 32'h000A_03A6);
    build_frame(8'h1F, 2'b00, 1'b0, 1'b0, 1'b1, len, bits);
    check("model_5n2_1f", {16'(len), bits}, 32'h0008_00FE);
    build_frame(8'hFF, 2'b00, 1'b1, 1'b1, 1'b1, len, bits);
    check("model_5e2_ff", {16'(len), bits}, 32'h0009_01FE);

    @(posedge pclk);
    #2;
    presetn = 1'b1;

    // 8N1 single character
    p0 = act_pops; d0 = act_dones;
    send(8'hA5);
    wait_idle("idle_8n1");
    check("pops_8n1", 32'(act_pops - p0), 32'd1);
    check("dones_8n1", 32'(act_dones - d0), 32'd1);
    check("empty_after_8n1", 32'(tx_if.tx_empty), 32'd1);

    // 7E1 with mid-frame config change, then 7O1
    tx_if.wls = 2'b10; tx_if.pen = 1'b1; tx_if.eps = 1'b1;
    p0 = act_pops; d0 = act_dones;
    send(8'h53);
    wait_q_le(6, "reach_data_7e1");
    @(posedge pclk);
    #2;
    tx_if.wls = 2'b00; tx_if.pen = 1'b0; tx_if.eps = 1'b0; tx_if.stb = 1'b1;
    wait_idle("idle_7e1");
    tx_if.wls = 2'b10; tx_if.pen = 1'b1; tx_if.eps = 1'b0; tx_if.stb = 1'b0;
    send(8'h53);
    wait_idle("idle_7o1");
    check("dones_7x1", 32'(act_dones - d0), 32'd2);

    // 5-bit, two stop bits; upper FIFO bits must not matter
    tx_if.wls = 2'b00; tx_if.pen = 1'b0; tx_if.eps = 1'b1; tx_if.stb = 1'b1;
    send(8'h1F);
    wait_idle("idle_5n2");
    tx_if.pen = 1'b1;
    send(8'hFF);
    send(8'h1F);
    wait_idle("idle_5e2");

    // Back-to-back characters, no idle bit between frames
    tx_if.wls = 2'b11; tx_if.pen = 1'b0; tx_if.eps = 1'b0; tx_if.stb = 1'b0;
    p0 = act_pops; d0 = act_dones;
    send(8'h00);
    send(8'hFF);
    wait_idle("idle_b2b");
    check("pops_b2b", 32'(act_pops - p0), 32'd2);
    check("dones_b2b", 32'(act_dones - d0), 32'd2);

    // Break requested mid-frame: frame completes, three low periods, one mark, idle
    p0 = act_pops; d0 = act_dones;
    send(8'h55);
    wait_q_le(8, "reach_data_brk");
    @(posedge pclk);
    #2;
    tx_if.brk = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back('{b: 1'b0, sof: 1'b0, eof: 1'b0, act: 1'b1});
    exp_q.push_back('{b: 1'b1, sof: 1'b0, eof: 1'b0, act: 1'b1});
    wait_q_le(1, "reach_last_break");
    @(posedge pclk);
    #2;
    tx_if.brk = 1'b0;
    wait_idle("idle_brk");
    check("pops_brk", 32'(act_pops - p0), 32'd1);
    check("dones_brk", 32'(act_dones - d0), 32'd1);

    // Enable dropped mid-DATA
    p0 = act_pops; d0 = act_dones;
    send(8'h3C);
    wait_q_le(5, "reach_data_abort");
    @(posedge pclk);
    #2;
    tx_if.utten = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    check("abort_txd", 32'(tx_if.uart_txd), 32'd1);
    check("abort_busy", 32'(tx_if.tx_busy), 32'd0);
    repeat (40) @(negedge pclk);
    check("abort_pops", 32'(act_pops - p0), 32'd1);
    check("abort_dones", 32'(act_dones - d0), 32'd0);
    @(posedge pclk);
    #2;
    tx_if.utten = 1'b1;

    // Reset mid-frame, then release on a tick cycle with a character waiting
    send(8'h81);
    wait_q_le(4, "reach_data_reset");
    @(posedge pclk);
    #3;
    presetn = 1'b0;
    #1;
    check("rst_mid_txd", 32'(tx_if.uart_txd), 32'd1);
    check("rst_mid_busy", 32'(tx_if.tx_busy), 32'd0);
    check("rst_mid_done", 32'(tx_if.tx_frame_done), 32'd0);
    check("rst_mid_pop", 32'(tx_if.tx_fifo_pop), 32'd0);
    repeat (3) @(negedge pclk);
    @(posedge pclk);
    #2;
    fifo_q.push_back(8'h0F);
    refresh_fifo();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge pclk);
      #2;
      if (tx_if.bit_tick) begin
        found = 1'b1;
        break;
      end
    end
    check("find_tick_cycle", 32'(found), 32'd1);
    presetn = 1'b1;
    push_frame(8'h0F);
    p0 = act_pops; d0 = act_dones;
    @(negedge pclk);
    check("rst_release_tick_pop", 32'(tx_if.tx_fifo_pop), 32'd0);
    check("rst_release_tick_busy", 32'(tx_if.tx_busy), 32'd0);
    wait_idle("idle_after_reset");
    check("pops_after_reset", 32'(act_pops - p0), 32'd1);
    check("dones_after_reset", 32'(act_dones - d0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
